uart_rx_fifo: RTL and testbench

//   UART 8N1 receive front-end that feeds the core's IN instruction and the

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART 8N1 receiver feeding a first-word-fall-through byte FIFO
// Ports: CLK clock; RST async active-high reset; UART_RX serial input (idle high);
//   rx_data/rx_valid/rx_ready head-byte valid/ready stream; rx_count occupancy;
//   overrun/frame_err sticky error flags, cleared by err_clear.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  UART_RX,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [FIFO_WIDTH:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  err_clear
);
  localparam int DEPTH = 2 ** FIFO_WIDTH;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sr, sr_n;
  logic push, bad_stop;
  logic [7:0] mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wp, rp;
  logic full, pop, wr;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sr <= '0;
    end else begin
      s1 <= UART_RX;
      rxs <= s1;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sr <= sr_n;
    end
  end
  // Returning to IDLE at the mid-stop-bit sample leaves half a bit to catch a back-to-back start edge.
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bit_n = bit_idx;
    sr_n = sr;
    push = 1'b0;
    bad_stop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        bit_n = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sr_n = {rxs, sr[7:1]};
        bit_n = bit_idx + 3'd1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      default: if (cnt == LAST) begin
        cnt_n = '0;
        state_n = IDLE;
        push = rxs;
        bad_stop = !rxs;
      end
    endcase
  end
  assign rx_valid = rx_count != '0;
  assign rx_data = rx_valid ? mem[rp] : 8'h00;
  assign full = rx_count == (FIFO_WIDTH+1)'(DEPTH);
  assign pop = rx_valid && rx_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign wr = push && (!full || pop);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
      rx_count <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) mem[wp] <= sr;
      wp <= wr ? wp + FIFO_WIDTH'(1) : wp;
      rp <= pop ? rp + FIFO_WIDTH'(1) : rp;
      rx_count <= rx_count + (FIFO_WIDTH+1)'(wr) - (FIFO_WIDTH+1)'(pop);
      overrun <= (overrun && !err_clear) || (push && full && !pop);
      frame_err <= (frame_err && !err_clear) || bad_stop;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue model
module tb_uart_rx_fifo;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic UART_RX = 1'b1;
  logic rx_ready = 1'b0;
  logic err_clear = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [4:0] rx_count;
  logic overrun, frame_err;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit m_ovr = 1'b0;
  bit m_fe = 1'b0;
  uart_rx_fifo #(.CLKS_PER_BIT(4), .FIFO_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err),
    .err_clear(err_clear)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic [7:0] hd;
    hd = q.size() != 0 ? q[0] : 8'h00;
    chk({tag, ".valid"}, {31'b0, rx_valid}, {31'b0, q.size() != 0});
    chk({tag, ".data"}, {24'b0, rx_data}, {24'b0, hd});
    chk({tag, ".count"}, {27'b0, rx_count}, 32'(q.size()));
    chk({tag, ".overrun"}, {31'b0, overrun}, {31'b0, m_ovr});
    chk({tag, ".frame_err"}, {31'b0, frame_err}, {31'b0, m_fe});
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input bit pop_at_push);
    bit popping;
    bit was_full;
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (4) @(negedge CLK);
    end
    UART_RX = stop;
    repeat (4) @(negedge CLK);
    UART_RX = 1'b1;
    if (pop_at_push) begin
      rx_ready = 1'b1;
      @(negedge CLK);
      rx_ready = 1'b0;
    end
    repeat (8) @(negedge CLK);
    was_full = q.size() == 16;
    popping = pop_at_push && q.size() != 0;
    if (popping) void'(q.pop_front());
    if (!stop) m_fe = 1'b1;
    else if (was_full && !popping) m_ovr = 1'b1;
    else q.push_back(b);
  endtask
  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic clear_err();
    err_clear = 1'b1;
    @(negedge CLK);
    err_clear = 1'b0;
    m_ovr = 1'b0;
    m_fe = 1'b0;
  endtask
  initial begin
    logic [7:0] rb;
    @(negedge CLK);
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check_all("post_reset");
    send(8'hA5, 1'b1, 1'b0);
    check_all("a5_rx");
    pop_one();
    check_all("a5_pop");
    pop_one();
    check_all("pop_empty");
    UART_RX = 1'b0;
    @(negedge CLK);
    UART_RX = 1'b1;
    repeat (12) @(negedge CLK);
    check_all("glitch");
    send(8'h3C, 1'b0, 1'b0);
    check_all("bad_stop");
    clear_err();
    check_all("fe_clear");
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
    check_all("fill16");
    send(8'hFF, 1'b1, 1'b0);
    check_all("overrun");
    for (int i = 0; i < 16; i++) begin
      check_all("drain");
      pop_one();
    end
    check_all("drained");
    clear_err();
    check_all("ovr_clear");
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b1, 1'b0);
    check_all("refill");
    send(8'h77, 1'b1, 1'b1);
    check_all("full_pushpop");
    while (q.size() != 0) begin
      check_all("drain77");
      pop_one();
    end
    check_all("drained77");
    send(8'h12, 1'b1, 1'b0);
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      UART_RX = i % 2 == 0;
      repeat (4) @(negedge CLK);
    end
    RST = 1'b1;
    UART_RX = 1'b1;
    q.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    repeat (2) @(negedge CLK);
    check_all("mid_reset");
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    send(8'h81, 1'b1, 1'b0);
    check_all("after_reset");
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      send(rb, $urandom_range(0, 7) != 0, 1'b0);
      check_all("rand_rx");
      repeat ($urandom_range(0, 2)) pop_one();
      check_all("rand_pop");
      if ($urandom_range(0, 4) == 0) clear_err();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
